// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine.
//   - pattern mode codes carried on cfg_mode
//   - control FSM and breathe direction encodings
//   - clog2 helper used to size the tick prescaler
package led_pattern_pkg;

    localparam logic [2:0] MODE_OFF     = 3'd0;
    localparam logic [2:0] MODE_ON      = 3'd1;
    localparam logic [2:0] MODE_BLINK   = 3'd2;
    localparam logic [2:0] MODE_CHASE   = 3'd3;
    localparam logic [2:0] MODE_BREATHE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

    // Modes that produce a running pattern; everything else parks in IDLE.
    function automatic logic mode_is_active(input logic [2:0] mode);
        return (mode >= MODE_ON) && (mode <= MODE_BREATHE);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing the pattern tick.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   tick : high for one clock when the count is DIV-1
module tick_gen
    import led_pattern_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             W    = clog2(DIV);
    localparam logic [W-1:0]   LAST = W'(DIV - 1);

    logic [W-1:0] cnt_r;

    // Prescaler count 0..DIV-1, wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + W'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern engine (off / on / blink / chase / breathe).
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   cfg_valid  : config request
//   cfg_ready  : config accepted this cycle when high (low only in APPLY)
//   cfg_mode   : 0 OFF, 1 ON, 2 BLINK, 3 CHASE, 4 BREATHE, 5-7 reserved
//   cfg_period : ticks per pattern step, 0 behaves as 1
//   cfg_err    : sticky flag, last accepted mode was reserved
//   light      : registered light outputs
//   step_pulse : one-clock pulse on every pattern step
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 1_000,
    parameter int N_CH       = 8,
    parameter int PWM_BITS   = 8,
    parameter int DEF_PERIOD = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [2:0]          cfg_mode,
    input  logic [15:0]         cfg_period,
    output logic                cfg_err,
    output logic [N_CH-1:0]     light,
    output logic                step_pulse
);

    localparam int                  DIV          = CLK_HZ / TICK_HZ;
    localparam logic [PWM_BITS-1:0] DUTY_MAX     = '1;
    localparam logic [15:0]         DEF_PERIOD_C = 16'(DEF_PERIOD);
    localparam logic [N_CH-1:0]     CHASE_INIT   = N_CH'(1);

    logic                 tick_s;
    logic                 accept_s;
    logic                 step_s;

    state_t               state_r, state_nxt_s;
    logic [2:0]           mode_r;
    logic [15:0]          period_r;
    logic [15:0]          step_cnt_r, step_cnt_nxt_s;
    logic [PWM_BITS-1:0]  pwm_cnt_r, pwm_nxt_s;
    logic [PWM_BITS-1:0]  duty_r, duty_nxt_s;
    dir_t                 dir_r, dir_nxt_s;
    logic [N_CH-1:0]      chase_r, chase_nxt_s;
    logic                 blink_r, blink_nxt_s;
    logic [N_CH-1:0]      light_r, light_nxt_s;
    logic                 cfg_ready_r;
    logic                 cfg_err_r;
    logic                 step_pulse_r;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // cfg_ready_r is low exactly in APPLY, so an accept can never land there.
    assign accept_s = cfg_valid && cfg_ready_r;

    // An accept in the same cycle discards the step that would have happened.
    assign step_s = (state_r == ST_RUN) && tick_s &&
                    (step_cnt_r == (period_r - 16'd1)) && !accept_s;

    // Control FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_APPLY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (mode_is_active(mode_r)) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s) begin
                    state_nxt_s = ST_APPLY;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pattern state next values: step counter, PWM counter, blink, chase, breathe.
    always_comb begin
        step_cnt_nxt_s = step_cnt_r;
        pwm_nxt_s      = pwm_cnt_r + PWM_BITS'(1);
        duty_nxt_s     = duty_r;
        dir_nxt_s      = dir_r;
        chase_nxt_s    = chase_r;
        blink_nxt_s    = blink_r;
        if (accept_s) begin
            step_cnt_nxt_s = 16'd0;
            pwm_nxt_s      = '0;
            duty_nxt_s     = '0;
            dir_nxt_s      = DIR_UP;
            chase_nxt_s    = CHASE_INIT;
            blink_nxt_s    = 1'b0;
        end else begin
            if ((state_r == ST_RUN) && tick_s) begin
                if (step_s) begin
                    step_cnt_nxt_s = 16'd0;
                end else begin
                    step_cnt_nxt_s = step_cnt_r + 16'd1;
                end
            end else begin
                step_cnt_nxt_s = step_cnt_r;
            end
            if (step_s) begin
                blink_nxt_s = ~blink_r;
                chase_nxt_s = {chase_r[N_CH-2:0], chase_r[N_CH-1]};
                // Endpoints turn around immediately so each is held one step only.
                case (dir_r)
                    DIR_UP: begin
                        if (duty_r == DUTY_MAX) begin
                            dir_nxt_s  = DIR_DOWN;
                            duty_nxt_s = DUTY_MAX - PWM_BITS'(1);
                        end else begin
                            duty_nxt_s = duty_r + PWM_BITS'(1);
                        end
                    end
                    DIR_DOWN: begin
                        if (duty_r == '0) begin
                            dir_nxt_s  = DIR_UP;
                            duty_nxt_s = PWM_BITS'(1);
                        end else begin
                            duty_nxt_s = duty_r - PWM_BITS'(1);
                        end
                    end
                    default: begin
                        dir_nxt_s  = DIR_UP;
                        duty_nxt_s = '0;
                    end
                endcase
            end else begin
                blink_nxt_s = blink_r;
                chase_nxt_s = chase_r;
            end
        end
    end

    // Light decode from next pattern state, so the lights change on the same
    // edge as step_pulse. The old pattern is held through the accept cycle.
    always_comb begin
        light_nxt_s = light_r;
        if (accept_s) begin
            light_nxt_s = light_r;
        end else begin
            case (mode_r)
                MODE_ON:      light_nxt_s = '1;
                MODE_BLINK:   light_nxt_s = {N_CH{blink_nxt_s}};
                MODE_CHASE:   light_nxt_s = chase_nxt_s;
                MODE_BREATHE: light_nxt_s = {N_CH{(pwm_nxt_s < duty_nxt_s)}};
                default:      light_nxt_s = '0;
            endcase
        end
    end

    // FSM state, configuration latch and handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            mode_r       <= MODE_OFF;
            period_r     <= DEF_PERIOD_C;
            cfg_ready_r  <= 1'b1;
            cfg_err_r    <= 1'b0;
            step_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cfg_ready_r  <= !accept_s;
            step_pulse_r <= step_s;
            if (accept_s) begin
                mode_r    <= cfg_mode;
                period_r  <= (cfg_period == 16'd0) ? 16'd1 : cfg_period;
                cfg_err_r <= (cfg_mode > MODE_BREATHE);
            end else begin
                mode_r    <= mode_r;
                period_r  <= period_r;
                cfg_err_r <= cfg_err_r;
            end
        end
    end

    // Pattern state registers and the light output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_cnt_r <= 16'd0;
            pwm_cnt_r  <= '0;
            duty_r     <= '0;
            dir_r      <= DIR_UP;
            chase_r    <= CHASE_INIT;
            blink_r    <= 1'b0;
            light_r    <= '0;
        end else begin
            step_cnt_r <= step_cnt_nxt_s;
            pwm_cnt_r  <= pwm_nxt_s;
            duty_r     <= duty_nxt_s;
            dir_r      <= dir_nxt_s;
            chase_r    <= chase_nxt_s;
            blink_r    <= blink_nxt_s;
            light_r    <= light_nxt_s;
        end
    end

    assign cfg_ready  = cfg_ready_r;
    assign cfg_err    = cfg_err_r;
    assign light      = light_r;
    assign step_pulse = step_pulse_r;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (DIV=10, N_CH=4, PWM_BITS=3).
module tb_led_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_mode = 3'd0;
    logic [15:0] cfg_period = 16'd0;
    logic        cfg_err;
    logic [3:0]  light;
    logic        step_pulse;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];

    typedef struct {
        logic [2:0]  mode;
        logic [15:0] period;
        logic [3:0]  exp_light;
        logic        exp_err;
    } vec_t;

    vec_t vecs[9];

    led_pattern_gen #(
        .CLK_HZ   (100),
        .TICK_HZ  (10),
        .N_CH     (4),
        .PWM_BITS (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_period (cfg_period),
        .cfg_err    (cfg_err),
        .light      (light),
        .step_pulse (step_pulse)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance negedge by negedge until step_pulse is seen or the budget runs out.
    task automatic wait_step(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (step_pulse === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("step_timeout", 32'd0, 32'd1);
    endtask

    // One-cycle config request, then handshake and 2-clock visibility checks.
    task automatic do_cfg(input logic [2:0] m, input logic [15:0] p,
                          input logic [3:0] exp_light, input logic exp_err);
        @(negedge clk);
        chk("ready_before_accept", {31'd0, cfg_ready}, 32'd1);
        cfg_valid  = 1'b1;
        cfg_mode   = m;
        cfg_period = p;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        @(negedge clk);
        chk("ready_in_apply", {31'd0, cfg_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_apply", {31'd0, cfg_ready}, 32'd1);
        chk("light_after_cfg", {28'd0, light}, {28'd0, exp_light});
        chk("err_after_cfg", {31'd0, cfg_err}, {31'd0, exp_err});
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        int cnt, last, hi, e;

        vecs[0] = '{3'd0, 16'd5,   4'b0000, 1'b0};
        vecs[1] = '{3'd1, 16'd5,   4'b1111, 1'b0};
        vecs[2] = '{3'd6, 16'd5,   4'b0000, 1'b1};
        vecs[3] = '{3'd1, 16'd5,   4'b1111, 1'b0};
        vecs[4] = '{3'd7, 16'd0,   4'b0000, 1'b1};
        vecs[5] = '{3'd3, 16'd100, 4'b0001, 1'b0};
        vecs[6] = '{3'd2, 16'd100, 4'b0000, 1'b0};
        vecs[7] = '{3'd4, 16'd100, 4'b0000, 1'b0};
        vecs[8] = '{3'd5, 16'd100, 4'b0000, 1'b1};

        // Reset state and quiet OFF mode.
        #205 rst = 1'b1;
        @(negedge clk);
        chk("rst_light", {28'd0, light}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_err", {31'd0, cfg_err}, 32'd0);
        cnt = 0; hi = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (step_pulse !== 1'b0) cnt++;
            if (light !== 4'b0000) hi++;
        end
        chk("off_step_pulses", cnt, 32'd0);
        chk("off_light_cycles", hi, 32'd0);

        // Static config table: handshake, immediate pattern, error flag.
        for (int v = 0; v < 9; v++) begin
            do_cfg(vecs[v].mode, vecs[v].period, vecs[v].exp_light, vecs[v].exp_err);
        end

        // Valid held through APPLY must not cause a second accept.
        @(negedge clk);
        cfg_valid = 1'b1; cfg_mode = 3'd1; cfg_period = 16'd3;
        @(posedge clk);
        @(negedge clk);
        chk("hold_ready_apply", {31'd0, cfg_ready}, 32'd0);
        @(posedge clk);
        #1 cfg_valid = 1'b0;
        @(negedge clk);
        chk("hold_single_accept", {31'd0, cfg_ready}, 32'd1);
        chk("hold_light_on", {28'd0, light}, 32'hf);
        chk("hold_err_clear", {31'd0, cfg_err}, 32'd0);

        // BLINK period 2: 20-clk toggles, 5 pulses in a 100-clk window.
        do_cfg(3'd2, 16'd2, 4'b0000, 1'b0);
        exp_q.push_back(4'hf); exp_q.push_back(4'h0); exp_q.push_back(4'hf);
        exp_q.push_back(4'h0); exp_q.push_back(4'hf);
        wait_step(60, got);
        if (got) begin
            cnt = 1; last = cyc;
            e = exp_q.pop_front();
            chk("blink_step0", {28'd0, light}, e);
            for (int i = 1; i < 100; i++) begin
                @(negedge clk);
                if (step_pulse === 1'b1) begin
                    cnt++;
                    chk("blink_spacing", cyc - last, 32'd20);
                    last = cyc;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("blink_step", {28'd0, light}, e);
                    end
                end
            end
            chk("blink_pulse_count", cnt, 32'd5);
        end
        exp_q.delete();

        // Period 0 behaves as 1: steps 10 clocks apart.
        do_cfg(3'd2, 16'd0, 4'b0000, 1'b0);
        wait_step(40, got);
        last = cyc;
        chk("p0_first_light", {28'd0, light}, 32'hf);
        wait_step(40, got);
        chk("p0_spacing", cyc - last, 32'd10);
        chk("p0_second_light", {28'd0, light}, 32'h0);

        // CHASE period 1 with wrap from bit3 to bit0.
        do_cfg(3'd3, 16'd1, 4'b0001, 1'b0);
        exp_q.push_back(4'b0010); exp_q.push_back(4'b0100); exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
        last = -1;
        while (exp_q.size() > 0) begin
            wait_step(40, got);
            if (!got) break;
            e = exp_q.pop_front();
            chk("chase_step", {28'd0, light}, e);
            if (last >= 0) chk("chase_spacing", cyc - last, 32'd10);
            last = cyc;
        end
        exp_q.delete();

        // BREATHE period 1: high clocks in 8 consecutive clocks equal the duty.
        do_cfg(3'd4, 16'd1, 4'b0000, 1'b0);
        for (int d = 1; d <= 7; d++) exp_q.push_back(d);
        for (int d = 6; d >= 0; d--) exp_q.push_back(d);
        exp_q.push_back(1);
        while (exp_q.size() > 0) begin
            wait_step(40, got);
            if (!got) break;
            e = exp_q.pop_front();
            hi = (light === 4'hf) ? 1 : 0;
            for (int k = 1; k < 8; k++) begin
                @(negedge clk);
                if (light === 4'hf) hi++;
            end
            chk("breathe_duty", hi, e);
        end
        exp_q.delete();

        // Async reset mid-CHASE, asserted and released between clock edges.
        do_cfg(3'd3, 16'd1, 4'b0001, 1'b0);
        wait_step(40, got);
        wait_step(40, got);
        @(posedge clk);
        #5 rst = 1'b0;
        #1;
        chk("async_rst_light", {28'd0, light}, 32'd0);
        chk("async_rst_ready", {31'd0, cfg_ready}, 32'd1);
        chk("async_rst_pulse", {31'd0, step_pulse}, 32'd0);
        #2 rst = 1'b1;
        cnt = 0; hi = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (step_pulse !== 1'b0) cnt++;
            if (light !== 4'b0000) hi++;
        end
        chk("post_rst_pulses", cnt, 32'd0);
        chk("post_rst_light", hi, 32'd0);
        do_cfg(3'd1, 16'd4, 4'b1111, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
